// File: rtl/mem_access_unit.sv
// Memory access stage: passes ALU results through, and runs loads/stores
// as a three-state handshake (IDLE -> ACCESS -> RESP) against a memory port
// with an ack, stalling the upstream pipeline while the access is in flight.
// A load that never gets an ack is abandoned after 255 cycles, returning a
// poison value and raising a sticky error flag.
module mem_access_unit (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic [1:0]  MEM_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [1:0]  WB_o,
  output logic [31:0] addr_o,
  output logic [31:0] data_o,
  output logic [4:0]  rd_o,
  output logic        stall_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [7:0]  TMO_LAST = 8'd254;
  localparam logic [31:0] POISON   = 32'hDEAD_BEEF;

  state_t      state;
  logic [1:0]  wb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [31:0] result_q;
  logic [7:0]  tmo_cnt;
  logic        mem_op;

  // A live instruction with either MemRead or MemWrite set needs the memory.
  assign mem_op = valid_i && (MEM_i != 2'b00);

  // FSM: latch the op in IDLE, wait for ack or timeout in ACCESS, emit one
  // result beat in RESP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wb_q     <= 2'b00;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rd_q     <= 5'd0;
      we_q     <= 1'b0;
      result_q <= 32'd0;
      tmo_cnt  <= 8'd0;
      err_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            wb_q    <= WB_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            rd_q    <= rd_i;
            // MemWrite wins when both bits are set.
            we_q    <= MEM_i[0];
            tmo_cnt <= 8'd0;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          if (mem_ack_i) begin
            result_q <= we_q ? 32'd0 : mem_rdata_i;
            state    <= RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            // This is the 255th cycle without an ack: give up.
            tmo_cnt  <= 8'd255;
            err_o    <= 1'b1;
            result_q <= we_q ? 32'd0 : POISON;
            state    <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          // Upstream sees the same instruction this cycle; it is not re-issued.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output muxing: pass-through or bubble in IDLE, bubble in ACCESS,
  // latched instruction plus result in RESP.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = 32'd0;
    mem_wdata_o = 32'd0;
    WB_o        = 2'b00;
    addr_o      = 32'd0;
    data_o      = 32'd0;
    rd_o        = 5'd0;
    stall_o     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op) begin
          stall_o = 1'b1;
        end else begin
          WB_o   = valid_i ? WB_i : 2'b00;
          addr_o = addr_i;
          rd_o   = rd_i;
        end
      end
      ACCESS: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        stall_o     = 1'b1;
      end
      RESP: begin
        WB_o   = wb_q;
        addr_o = addr_q;
        data_o = result_q;
        rd_o   = rd_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [1:0]  MEM_i;
  logic [1:0]  WB_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic [1:0]  WB_o;
  logic [31:0] addr_o;
  logic [31:0] data_o;
  logic [4:0]  rd_o;
  logic        stall_o;
  logic        err_o;

  int n_total = 0;
  int n_pass  = 0;

  mem_access_unit dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .MEM_i       (MEM_i),
    .WB_i        (WB_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .rd_i        (rd_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_ack_i   (mem_ack_i),
    .mem_rdata_i (mem_rdata_i),
    .WB_o        (WB_o),
    .addr_o      (addr_o),
    .data_o      (data_o),
    .rd_o        (rd_o),
    .stall_o     (stall_o),
    .err_o       (err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one instruction onto the inputs.
  task automatic drive(input logic v, input logic [1:0] mem, input logic [1:0] wb,
                       input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    valid_i = v; MEM_i = mem; WB_i = wb; addr_i = a; wdata_i = wd; rd_i = rd;
  endtask

  // Advance to the next falling edge and let combinational outputs settle.
  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    drive(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    repeat (2) @(posedge clk_i);
    step();
    n_total++; if (stall_o !== 1'b0) $display("FAIL rst_stall: got %b want 0", stall_o); else n_pass++;
    n_total++; if (mem_req_o !== 1'b0) $display("FAIL rst_req: got %b want 0", mem_req_o); else n_pass++;
    n_total++; if (mem_we_o !== 1'b0) $display("FAIL rst_we: got %b want 0", mem_we_o); else n_pass++;
    n_total++; if (mem_addr_o !== 32'd0) $display("FAIL rst_maddr: got %h want 0", mem_addr_o); else n_pass++;
    n_total++; if (mem_wdata_o !== 32'd0) $display("FAIL rst_mwdata: got %h want 0", mem_wdata_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rst_err: got %b want 0", err_o); else n_pass++;
    rst_i = 1'b0;
    step();
    n_total++; if ({WB_o, addr_o, data_o, rd_o} !== 71'd0)
      $display("FAIL post_rst_outs: got WB=%b addr=%h data=%h rd=%0d want all 0", WB_o, addr_o, data_o, rd_o);
    else n_pass++;
    n_total++; if ({stall_o, mem_req_o, err_o} !== 3'b000)
      $display("FAIL post_rst_ctl: got %b want 000", {stall_o, mem_req_o, err_o}); else n_pass++;
  endtask

  task automatic test_alu_pass(input string tag);
    drive(1'b1, 2'b00, 2'b10, 32'h0000_0014, 32'd0, 5'd3);
    #1;
    n_total++; if (WB_o !== 2'b10) $display("FAIL %s_wb: got %b want 10", tag, WB_o); else n_pass++;
    n_total++; if (addr_o !== 32'h14) $display("FAIL %s_addr: got %h want 14", tag, addr_o); else n_pass++;
    n_total++; if (rd_o !== 5'd3) $display("FAIL %s_rd: got %0d want 3", tag, rd_o); else n_pass++;
    n_total++; if (data_o !== 32'd0) $display("FAIL %s_data: got %h want 0", tag, data_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0) $display("FAIL %s_stall: got %b want 0", tag, stall_o); else n_pass++;
    n_total++; if (mem_req_o !== 1'b0) $display("FAIL %s_req: got %b want 0", tag, mem_req_o); else n_pass++;
  endtask

  task automatic test_load();
    drive(1'b1, 2'b10, 2'b11, 32'h40, 32'd0, 5'd5);
    #1;
    // IDLE cycle: stall with a bubble, no request yet
    n_total++; if (stall_o !== 1'b1) $display("FAIL ld_idle_stall: got %b want 1", stall_o); else n_pass++;
    n_total++; if ({WB_o, rd_o} !== 7'd0) $display("FAIL ld_idle_bubble: got WB=%b rd=%0d want 0", WB_o, rd_o); else n_pass++;
    n_total++; if (mem_req_o !== 1'b0) $display("FAIL ld_idle_req: got %b want 0", mem_req_o); else n_pass++;
    step();
    // ACCESS cycle: request out, ack returned this cycle
    n_total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b0 || mem_addr_o !== 32'h40)
      $display("FAIL ld_access: got req=%b we=%b addr=%h want 1 0 40", mem_req_o, mem_we_o, mem_addr_o);
    else n_pass++;
    n_total++; if (stall_o !== 1'b1 || data_o !== 32'd0) $display("FAIL ld_access_stall: got stall=%b data=%h want 1 0", stall_o, data_o); else n_pass++;
    mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    // RESP beat
    n_total++; if (stall_o !== 1'b0) $display("FAIL ld_resp_stall: got %b want 0", stall_o); else n_pass++;
    n_total++; if (WB_o !== 2'b11) $display("FAIL ld_resp_wb: got %b want 11", WB_o); else n_pass++;
    n_total++; if (data_o !== 32'h1234_5678) $display("FAIL ld_resp_data: got %h want 12345678", data_o); else n_pass++;
    n_total++; if (rd_o !== 5'd5 || addr_o !== 32'h40) $display("FAIL ld_resp_rd_addr: got rd=%0d addr=%h want 5 40", rd_o, addr_o); else n_pass++;
    n_total++; if (mem_req_o !== 1'b0) $display("FAIL ld_resp_req: got %b want 0", mem_req_o); else n_pass++;
    drive(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
    // Back in IDLE after exactly one RESP beat
    n_total++; if (data_o !== 32'd0 || WB_o !== 2'b00 || stall_o !== 1'b0)
      $display("FAIL ld_after: got data=%h WB=%b stall=%b want 0 00 0", data_o, WB_o, stall_o);
    else n_pass++;
  endtask

  task automatic test_store();
    drive(1'b1, 2'b01, 2'b00, 32'h80, 32'hCAFE_F00D, 5'd0);
    #1;
    n_total++; if (stall_o !== 1'b1) $display("FAIL st_idle_stall: got %b want 1", stall_o); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      step();
      n_total++; if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'hCAFE_F00D || mem_addr_o !== 32'h80)
        $display("FAIL st_access%0d: got req=%b we=%b wdata=%h addr=%h want 1 1 cafef00d 80",
                 i, mem_req_o, mem_we_o, mem_wdata_o, mem_addr_o);
      else n_pass++;
      if (i == 4) begin
        mem_ack_i = 1'b1; mem_rdata_i = 32'h5555_AAAA;
      end
    end
    step();
    mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    n_total++; if (stall_o !== 1'b0 || mem_req_o !== 1'b0) $display("FAIL st_resp_ctl: got stall=%b req=%b want 0 0", stall_o, mem_req_o); else n_pass++;
    n_total++; if (data_o !== 32'd0) $display("FAIL st_resp_data: got %h want 0", data_o); else n_pass++;
    n_total++; if (addr_o !== 32'h80) $display("FAIL st_resp_addr: got %h want 80", addr_o); else n_pass++;
    drive(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
  endtask

  task automatic test_timeout();
    int n;
    drive(1'b1, 2'b10, 2'b11, 32'h100, 32'd0, 5'd7);
    #1;
    step();
    n = 0;
    while (mem_req_o === 1'b1 && n < 300) begin
      n++;
      step();
    end
    n_total++; if (n !== 255) $display("FAIL tmo_cycles: got %0d ACCESS cycles want 255", n); else n_pass++;
    n_total++; if (data_o !== 32'hDEAD_BEEF) $display("FAIL tmo_data: got %h want deadbeef", data_o); else n_pass++;
    n_total++; if (err_o !== 1'b1) $display("FAIL tmo_err: got %b want 1", err_o); else n_pass++;
    n_total++; if (stall_o !== 1'b0 || rd_o !== 5'd7) $display("FAIL tmo_resp: got stall=%b rd=%0d want 0 7", stall_o, rd_o); else n_pass++;
    drive(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
    test_alu_pass("tmo_alu");
    step();
    n_total++; if (err_o !== 1'b1) $display("FAIL tmo_sticky: got %b want 1", err_o); else n_pass++;
  endtask

  task automatic test_reset_mid_access();
    drive(1'b1, 2'b10, 2'b01, 32'h200, 32'd0, 5'd9);
    #1;
    step();
    n_total++; if (mem_req_o !== 1'b1) $display("FAIL rma_access1: got req=%b want 1", mem_req_o); else n_pass++;
    step();
    // Second ACCESS cycle: assert reset, upstream squashes the instruction
    rst_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    drive(1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
    step();
    rst_i = 1'b0; mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
    n_total++; if (mem_req_o !== 1'b0 || stall_o !== 1'b0) $display("FAIL rma_ctl: got req=%b stall=%b want 0 0", mem_req_o, stall_o); else n_pass++;
    n_total++; if (err_o !== 1'b0) $display("FAIL rma_err: got %b want 0", err_o); else n_pass++;
    n_total++; if ({WB_o, data_o, rd_o} !== 39'd0) $display("FAIL rma_outs: got WB=%b data=%h rd=%0d want 0", WB_o, data_o, rd_o); else n_pass++;
    step();
    n_total++; if ({WB_o, data_o, rd_o, mem_req_o} !== 40'd0)
      $display("FAIL rma_no_resp: got WB=%b data=%h rd=%0d req=%b want 0", WB_o, data_o, rd_o, mem_req_o);
    else n_pass++;
  endtask

  task automatic test_spurious_ack();
    mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_0000;
    test_alu_pass("sack");
    step();
    test_alu_pass("sack2");
    mem_ack_i = 1'b0; mem_rdata_i = 32'd0;
  endtask

  initial begin
    test_reset();
    test_alu_pass("alu");
    step();
    test_load();
    test_store();
    test_timeout();
    step();
    test_reset_mid_access();
    test_spurious_ack();
    step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
